uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one UART transmit FIFO write port.
REQ-002 SHALL have parameter SIZE_DATA, default 9: data width, matching the transmit FIFO word.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: idle-grant watchdog limit in clocks.
REQ-004 SHALL have port i_clk, input, 1: the only clock.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_req_valid, input, NUM_REQ: per-requester data valid.
REQ-007 SHALL have port i_req_last, input, NUM_REQ: per-requester last word of packet.
REQ-008 SHALL have port i_req_data, input, NUM_REQ*SIZE_DATA: per-requester data; requester k occupies bits [k*SIZE_DATA +: SIZE_DATA].
REQ-009 SHALL have port o_req_ready, output, NUM_REQ: per-requester accept.
REQ-010 SHALL have port i_fifo_full, input, 1: transmit FIFO full.
REQ-011 SHALL have port o_en_wr, output, 1: FIFO write strobe.
REQ-012 SHALL have port o_data, output, SIZE_DATA: FIFO write data.
REQ-013 SHALL have port o_grant, output, NUM_REQ: one-hot current owner, zero when idle.
REQ-014 SHALL have port o_busy, output, 1: a packet is in progress.
REQ-015 SHALL have port o_timeout, output, 1: one-cycle pulse when the watchdog releases a grant.

Function
REQ-016 SHALL implement FSM states IDLE and XFER.
REQ-017 In IDLE with any i_req_valid bit high, SHALL pick one requester round-robin, starting from the priority pointer, register it in o_grant, and enter XFER on the next edge.
REQ-018 Requester latency SHALL be one clock: valid in cycle N gives o_grant in cycle N+1, with a first write possible in N+1.
REQ-019 In XFER, o_req_ready[g] SHALL equal ~i_fifo_full for the granted g, and 0 for all others.
REQ-020 o_en_wr SHALL equal i_req_valid[g] & o_req_ready[g], combinationally, and o_data SHALL equal the data slice of g.
REQ-021 A beat with i_req_last[g] high SHALL end the packet: return to IDLE and set the pointer to g+1 modulo NUM_REQ.
REQ-022 The grant SHALL hold for a whole packet; no other requester is served until last or timeout.
REQ-023 With i_fifo_full high, SHALL stall: no write and no ready, with grant and state kept.
REQ-024 In IDLE, o_en_wr, o_req_ready and o_grant SHALL all be 0.
REQ-025 The IDLE-to-XFER-to-IDLE turnaround SHALL cost one idle cycle between packets.
REQ-026 A single-word packet (valid and last together) SHALL be handled as a normal last beat.
REQ-027 A request that drops before its grant SHALL still be granted, and it waits in XFER.
REQ-028 o_busy SHALL equal the state being XFER.

Reset
REQ-029 Asserting i_rst_n low SHALL force, asynchronously, state IDLE, pointer 0, o_grant 0, o_timeout 0 and the watchdog count 0; a mid-packet reset drops the packet without further writes.

Configuration
REQ-030 With macro UART_TX_ARB_TIMEOUT_EN defined, a counter SHALL count XFER cycles with i_req_valid[g] low and clear on any accepted beat.
REQ-031 With that macro defined, reaching TIMEOUT_CYC SHALL return the FSM to IDLE, advance the pointer as on last, and pulse o_timeout.
REQ-032 A stall caused by i_fifo_full SHALL NOT count toward the watchdog.
REQ-033 With the macro undefined, there SHALL be no counter, o_timeout SHALL be tied 0, and the grant SHALL wait for last indefinitely.

Structure
REQ-034 Package uart_arb_pkg SHALL hold the state enum (IDLE, XFER) and the default NUM_REQ and TIMEOUT_CYC constants.
REQ-035 Sub-module rr_arbiter SHALL be combinational: inputs request vector and pointer, output one-hot pick; it SHALL be instantiated once.

Verification
REQ-036 Requester 0 sends 3 words 0x041,0x042,0x043 with last on the third -> o_en_wr for 3 cycles with matching o_data, grant 0001, then IDLE.
REQ-037 Requesters 0..3 all valid, 1-word packets, repeated -> grants in order 0,1,2,3,0, with one IDLE cycle between packets.
REQ-038 Requester 2 is mid-packet while requester 1 asserts valid -> requester 1 stays unready until requester 2's last is accepted.
REQ-039 i_fifo_full high for 5 cycles mid-packet -> no o_en_wr, grant held, no word lost or duplicated after the stall.
REQ-040 With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, the granted requester goes silent -> o_timeout pulses after 8 cycles, and the next requester is granted.
REQ-041 Reset asserted mid-packet -> outputs zero immediately, and after release requester 0 has first priority.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit-FIFO write-port arbiter.
package uart_arb_pkg;

  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_SIZE_DATA   = 9;
  localparam int unsigned DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, one-hot.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick
);

  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] unrot;
  logic           found;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    first = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        first[i] = 1'b1;
        found    = 1'b1;
      end
    end
    unrot = {{N{1'b0}}, first} << ptr;
    pick  = unrot[N-1:0] | unrot[2*N-1:N];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART transmit FIFO write port.
// Optional idle-grant watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned SIZE_DATA   = DEF_SIZE_DATA,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0]             i_req_last,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic                           i_fifo_full,
  output logic                           o_en_wr,
  output logic [SIZE_DATA-1:0]           o_data,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic                           o_busy,
  output logic                           o_timeout
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ and TIMEOUT_CYC must be at least 1");
  end

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] pick;
  logic [PTR_W-1:0]   gidx, gidx_next;
  logic               beat_last;
  logic               release_grant;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            g_valid;
`endif

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req  (i_req_valid),
    .ptr  (ptr_q),
    .pick (pick)
  );

  // Owner index and write-port datapath, all gated by the one-hot grant.
  always_comb begin
    gidx   = '0;
    o_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        gidx   = PTR_W'(k);
        o_data = i_req_data[k*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  assign gidx_next   = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + PTR_W'(1);
  assign o_req_ready = (state_q == XFER && !i_fifo_full) ? grant_q : '0;
  assign o_en_wr     = |(i_req_valid & o_req_ready);
  assign beat_last   = |(i_req_valid & o_req_ready & i_req_last);
  assign o_grant     = grant_q;
  assign o_busy      = (state_q == XFER);

  // Next-state: grant on any request, release on last beat or watchdog expiry.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    release_grant = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
    g_valid   = |(i_req_valid & grant_q);
`endif
    unique case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          state_d = XFER;
          grant_d = pick;
        end
      end
      XFER: begin
        if (beat_last) release_grant = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
        // Only owner silence counts; a full FIFO is backpressure, not idleness.
        if (o_en_wr) begin
          wd_d = '0;
        end else if (!g_valid && !i_fifo_full) begin
          if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
            wd_d          = '0;
            timeout_d     = 1'b1;
            release_grant = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (release_grant) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = gidx_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; watchdog scenario follows UART_TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ     = 4;
  localparam int unsigned SIZE_DATA   = 9;
  localparam int unsigned TIMEOUT_CYC = 8;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ*SIZE_DATA-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         fifo_full;
  logic                         en_wr;
  logic [SIZE_DATA-1:0]         data;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic                         timeout;

  int tests = 0;
  int fails = 0;

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .SIZE_DATA   (SIZE_DATA),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_last  (req_last),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_fifo_full (fifo_full),
    .o_en_wr     (en_wr),
    .o_data      (data),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [SIZE_DATA-1:0] v);
    req_data[k*SIZE_DATA +: SIZE_DATA] = v;
  endtask

  // Mid-cycle view of the write port; data only matters when a write happens.
  task automatic look(input string tag, input logic [3:0] g, input logic [3:0] rdy,
                      input logic wr, input logic [8:0] d);
    @(negedge clk);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    check({tag, ".en_wr"}, 32'(en_wr), 32'(wr));
    check({tag, ".busy"}, 32'(busy), 32'(g != 4'b0));
    if (wr) check({tag, ".data"}, 32'(data), 32'(d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.grant", 32'(grant), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.en_wr", 32'(en_wr), 32'h0);
    check("rst.ready", 32'(req_ready), 32'h0);
    check("rst.timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    tick();

    // Three-word packet from requester 0
    req_valid = 4'b0001;
    set_data(0, 9'h041);
    look("t1_idle", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();
    look("t1_w0", 4'b0001, 4'b0001, 1'b1, 9'h041);
    tick();
    set_data(0, 9'h042);
    look("t1_w1", 4'b0001, 4'b0001, 1'b1, 9'h042);
    tick();
    set_data(0, 9'h043);
    req_last = 4'b0001;
    look("t1_w2", 4'b0001, 4'b0001, 1'b1, 9'h043);
    tick();
    req_valid = '0;
    req_last  = '0;
    look("t1_done", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();

    // Reset mid-packet (pointer currently 1, so requester 1 wins first)
    req_valid = 4'b0010;
    set_data(1, 9'h0AA);
    look("t6_idle", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();
    look("t6_w0", 4'b0010, 4'b0010, 1'b1, 9'h0AA);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst.grant", 32'(grant), 32'h0);
    check("t6_rst.ready", 32'(req_ready), 32'h0);
    check("t6_rst.en_wr", 32'(en_wr), 32'h0);
    check("t6_rst.busy", 32'(busy), 32'h0);
    @(negedge clk);
    req_valid = 4'b0011;
    req_last  = 4'b0001;
    set_data(0, 9'h0F0);
    rst_n = 1'b1;
    tick();
    look("t6_prio", 4'b0001, 4'b0001, 1'b1, 9'h0F0);
    tick();
    req_valid = '0;
    req_last  = '0;
    do_reset();

    // All four requesters, single-word packets: 0,1,2,3,0 with an idle gap each
    req_valid = '1;
    req_last  = '1;
    for (int k = 0; k < 4; k++) set_data(k, 9'(9'h100 + k));
    for (int p = 0; p < 5; p++) begin
      look($sformatf("t2_gap%0d", p), 4'b0000, 4'b0000, 1'b0, 9'h0);
      tick();
      look($sformatf("t2_pkt%0d", p), 4'(1 << (p % 4)), 4'(1 << (p % 4)), 1'b1,
           9'(9'h100 + (p % 4)));
      tick();
    end
    req_valid = '0;
    req_last  = '0;

    // Requester 2 holds the port while requester 1 waits (pointer is 1)
    req_valid = 4'b0100;
    set_data(2, 9'h2A0);
    look("t3_idle", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();
    req_valid = 4'b0110;
    set_data(1, 9'h1B0);
    look("t3_w0", 4'b0100, 4'b0100, 1'b1, 9'h2A0);
    tick();
    set_data(2, 9'h2A1);
    look("t3_w1", 4'b0100, 4'b0100, 1'b1, 9'h2A1);
    tick();
    set_data(2, 9'h2A2);
    req_last = 4'b0100;
    look("t3_w2", 4'b0100, 4'b0100, 1'b1, 9'h2A2);
    tick();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    look("t3_gap", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();
    look("t3_r1", 4'b0010, 4'b0010, 1'b1, 9'h1B0);
    tick();
    req_valid = '0;
    req_last  = '0;

    // FIFO full for five cycles mid-packet (pointer is 2)
    req_valid = 4'b0100;
    set_data(2, 9'h300);
    look("t4_idle", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();
    look("t4_w0", 4'b0100, 4'b0100, 1'b1, 9'h300);
    tick();
    set_data(2, 9'h301);
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      look($sformatf("t4_stall%0d", s), 4'b0100, 4'b0000, 1'b0, 9'h0);
      tick();
    end
    fifo_full = 1'b0;
    look("t4_w1", 4'b0100, 4'b0100, 1'b1, 9'h301);
    tick();
    set_data(2, 9'h302);
    req_last = 4'b0100;
    look("t4_w2", 4'b0100, 4'b0100, 1'b1, 9'h302);
    tick();
    req_valid = '0;
    req_last  = '0;
    look("t4_done", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();

    // Granted requester 3 goes silent while requester 0 waits (pointer is 3)
    req_valid = 4'b1001;
    set_data(3, 9'h3C0);
    set_data(0, 9'h0D0);
    look("t5_idle", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();
    look("t5_w0", 4'b1000, 4'b1000, 1'b1, 9'h3C0);
    tick();
    req_valid = 4'b0001;
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int s = 0; s < 8; s++) begin
      look($sformatf("t5_quiet%0d", s), 4'b1000, 4'b1000, 1'b0, 9'h0);
      check($sformatf("t5_quiet%0d.timeout", s), 32'(timeout), 32'h0);
      tick();
    end
    look("t5_expire", 4'b0000, 4'b0000, 1'b0, 9'h0);
    check("t5_expire.timeout", 32'(timeout), 32'h1);
    tick();
    req_last = 4'b0001;
    look("t5_next", 4'b0001, 4'b0001, 1'b1, 9'h0D0);
    check("t5_next.timeout", 32'(timeout), 32'h0);
    tick();
`else
    for (int s = 0; s < 12; s++) begin
      look($sformatf("t5_quiet%0d", s), 4'b1000, 4'b1000, 1'b0, 9'h0);
      check($sformatf("t5_quiet%0d.timeout", s), 32'(timeout), 32'h0);
      tick();
    end
    req_valid = 4'b1001;
    req_last  = 4'b1000;
    set_data(3, 9'h3C1);
    look("t5_last", 4'b1000, 4'b1000, 1'b1, 9'h3C1);
    tick();
    req_last = 4'b0001;
    req_valid = 4'b0001;
    look("t5_gap", 4'b0000, 4'b0000, 1'b0, 9'h0);
    tick();
    look("t5_next", 4'b0001, 4'b0001, 1'b1, 9'h0D0);
    tick();
`endif
    req_valid = '0;
    req_last  = '0;
    look("t5_done", 4'b0000, 4'b0000, 1'b0, 9'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
